// File: rtl/fifo_uart_tx.sv
// Pops a byte from a synchronous FIFO and sends it as a UART 8N1 frame; tx/tx_busy/tx_done_tick lag state by one cycle.
// Frame is (DBIT+2)*CLKS_PER_BIT cycles from pop; the FIFO waits (no pop) while a frame is in flight or enable is low.
module fifo_uart_tx #(
    parameter int DBIT         = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [BW-1:0]   bit_cnt_q;
    logic [DBIT-1:0] shift_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;

    logic            bit_end;
    logic            tx_d;
    logic            busy_d;
    logic            done_d;

    assign bit_end = (clk_cnt_q == CLK_LAST);

    // Reset must veto the pop so the FIFO head survives a reset cycle.
    assign fifo_rd = (state_q == IDLE) && enable && !fifo_empty && !reset;

    assign tx_d   = (state_q == START) ? 1'b0 :
                    (state_q == DATA)  ? shift_q[0] : 1'b1;
    assign busy_d = (state_q != IDLE);
    assign done_d = (state_q == STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
            case (state_q)
                IDLE: begin
                    if (fifo_rd) begin
                        shift_q   <= fifo_data;
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        shift_q   <= shift_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit synchronous FIFO.
- Pops one byte whenever the FIFO is non-empty and transmission is enabled.
- Serializes each byte as a UART 8N1 frame on a single line: start bit, DBIT data bits LSB first, one stop bit.
- Drives the FIFO read strobe directly, so no glue logic sits between FIFO and serial pin.

Parameters:
- DBIT, 8, data bits per frame; equals FIFO word width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits new frames to start; never aborts a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DBIT  FIFO head word (r_data); valid while fifo_empty=0.
- fifo_rd  output  1  FIFO pop strobe (rd); one-cycle pulse per byte.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done_tick  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset, sampled on clk edge: state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, fifo_rd=0, bit counter=0, clock counter=0, shift register=0.
- fifo_rd is combinational: 1 iff state==IDLE && enable && !fifo_empty && !reset. It is never high in any other state.
- IDLE:
  - tx=1.
  - If fifo_rd is high, the shift register latches fifo_data on the same edge that pops the FIFO. The next state is START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, then the next state is DATA.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles, then shift right by one.
  - Repeats DBIT times, using bit counter 0..DBIT-1, then the next state is STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle of STOP, tx_done_tick=1 and the next state is IDLE.
- tx is registered: it changes on the edge after the state change, with no combinational path from inputs to tx.
- tx_busy=1 in START, DATA and STOP; 0 in IDLE.
- Frame length is (DBIT+2)*CLKS_PER_BIT cycles from the pop edge to the return to IDLE.
  - Back-to-back frames have exactly one IDLE cycle between them (tx=1), giving a pop period of (DBIT+2)*CLKS_PER_BIT+1 cycles.
- Clock counter width is clog2(CLKS_PER_BIT); it resets to 0 at every bit boundary. Bit counter width is clog2(DBIT). Neither counter wraps outside its range.
- Boundary conditions:
  - fifo_empty=1 in IDLE: no pop, tx stays 1 indefinitely.
  - fifo_empty changes during a frame: ignored.
  - enable falls mid-frame: the current frame completes normally and no further pop occurs.
  - enable rises while the FIFO is non-empty: pop on that same cycle.
  - Reset mid-frame: the frame is aborted, and on the next cycle tx=1 and tx_busy=0. The byte already popped is lost; no re-read occurs.
  - Reset and pop conditions in the same cycle: reset wins, fifo_rd=0, FIFO is unchanged.
  - fifo_data is never sampled outside the pop cycle.

Test Plan (CLKS_PER_BIT=4, DBIT=8, FIFO model returns head word on fifo_data):
- Reset held 2 cycles with FIFO non-empty -> tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0 throughout reset.
- Single byte 0xA5, enable=1 -> exactly one fifo_rd pulse.
  - tx over the 40 cycles after the pop edge, 4 cycles per symbol: 0,1,0,1,0,0,1,0,1,1.
  - tx_done_tick high at cycle 40 only.
  - tx_busy high for cycles 1..40.
- FIFO preloaded with 0x14,0x0A,0x0C,0x0B,0x09,0x08,0x07,0x06 -> 8 fifo_rd pulses spaced exactly 41 cycles apart.
  - The bench UART decoder recovers the same 8 bytes in order.
  - fifo_empty ends at 1; no further pulses.
- enable=0 with FIFO non-empty for 50 cycles -> fifo_rd never asserted, tx=1.
  - Then enable=1 for 1 cycle during IDLE -> one pop.
  - enable=0 mid-DATA -> that frame completes (tx_done_tick fires), and no second pop occurs.
- Reset asserted during data bit 3 of 0x5A -> next cycle tx=1, tx_busy=0, no tx_done_tick.
  - After release with FIFO holding 0x3C -> next pop occurs immediately and a correct 0x3C frame is sent.
- FIFO empties after one byte, then is refilled 100 cycles later with 0xFF -> tx stays 1 during the gap with no fifo_rd.
  - Frame 0xFF is sent as start 0 followed by nine 1-symbols (8 data bits plus stop).
